reg_writeback_unit: RTL and testbench
=====================================

Name: reg_writeback_unit

Overview:
- Write-side producer for the 16-entry x 16-bit register file.
- Collects completed results from the ALU and the data-memory load path, and arbitrates between them.
- Buffers results in a small in-order FIFO and drives the register file write port (rw, WD, RegWrite) with at most one write per cycle.
- Honours a pipeline stall input.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  load result accepted this cycle when high with mem_valid
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- stall  in  1  high: no write issued this cycle
- rw  out  ADDR_W  register file write address
- WD  out  DATA_W  register file write data
- RegWrite  out  1  register file write enable, one-cycle pulse per write
- count  out  clog2(DEPTH)+1  current FIFO occupancy
- fwd_addr  in  ADDR_W  forwarding lookup address
- fwd_hit  out  1  pending write to fwd_addr exists in FIFO
- fwd_data  out  DATA_W  data of newest pending write to fwd_addr

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empty, pointers 0, count=0.
  - RegWrite=0, rw=0, WD=0.
  - Pending entries are discarded; mid-operation reset is not an error.
- Readiness:
  - full = (count==DEPTH).
  - mem_ready = !full.
  - alu_ready = !full && !mem_valid.
  - Memory has fixed priority.
  - At most one enqueue per cycle.
  - Both ready outputs are combinational from full and mem_valid only; they never depend on alu_valid.
- Enqueue: on an edge with the selected valid&&ready, push {rd,data} at the tail.
- r0 drop: if the accepted rd==0, the handshake completes but nothing is enqueued.
- Issue: on an edge with !stall and count>0 (pre-edge occupancy), pop the head.
  - Register rw/WD from the head and set RegWrite=1 for the following cycle.
  - Otherwise RegWrite=0, and rw/WD hold their last values.
- Latency:
  - Accept at edge N gives the earliest RegWrite high in the cycle after edge N+1.
  - No enqueue-to-output bypass.
- Simultaneous push and pop in one edge: both occur; count unchanged.
- A push is never offered while full, so there is no full-push case.
- Order: writes issue in strict acceptance order; duplicate rd entries are all written, oldest first.
- Pointers wrap modulo DEPTH; count is range 0..DEPTH.

Optional Feature:
- Macro: REG_WB_FWD_EN.
- Defined:
  - fwd_hit=1 when fwd_addr!=0 and any occupied FIFO entry has rd==fwd_addr.
  - fwd_data = data of the newest such entry.
  - Purely combinational over the current FIFO contents; excludes the entry currently on rw/WD.
  - fwd_data=0 when there is no hit.
- Undefined: fwd_hit=0 and fwd_data=0 constant; ports still present.

Test Plan:
1. Reset and single write:
   - Assert rst → RegWrite=0, rw=0, WD=0, count=0, alu_ready=1, mem_ready=1.
   - Release rst; one cycle of alu_valid, alu_rd=3, alu_data=16'h1234 → count=1 after that edge.
   - Next cycle RegWrite=1, rw=3, WD=16'h1234 for exactly one cycle; count returns to 0.
2. Priority:
   - alu_valid (rd=2, 16'hAAAA) and mem_valid (rd=5, 16'h5555) together → mem_ready=1, alu_ready=0.
   - Hold ALU; it is accepted the next cycle.
   - Writes appear r5=5555, then r2=AAAA, on consecutive cycles.
3. Full and stall:
   - stall=1; push r1..r4 with data 16'h0001..0004 → count=4, alu_ready=mem_ready=0, RegWrite stays 0.
   - Drop stall → four consecutive RegWrite pulses r1..r4 in order; ready outputs return to 1 after the first pop.
4. r0 and mid-operation reset:
   - ALU push rd=0, data 16'hFFFF → handshake completes, count stays 0, no RegWrite.
   - Then stall=1, push 2 entries, pulse rst → count=0; no RegWrite after stall drops.
5. Forwarding (REG_WB_FWD_EN defined):
   - stall=1; push r7=16'h1111 then r7=16'h2222.
   - fwd_addr=7 → fwd_hit=1, fwd_data=16'h2222.
   - fwd_addr=0 → fwd_hit=0, fwd_data=0.
   - Macro undefined → fwd_hit=0 in all cases.

Source files
------------

// File: rtl/reg_writeback_unit.sv
// Register-file write-back unit: arbitrates ALU and load results into an in-order FIFO
// and issues at most one register write per cycle. Optional forwarding lookup: REG_WB_FWD_EN.
module reg_writeback_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ADDR_W-1:0]         alu_rd,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [ADDR_W-1:0]         mem_rd,
    input  logic [DATA_W-1:0]         mem_data,
    input  logic                      stall,
    output logic [ADDR_W-1:0]         rw,
    output logic [DATA_W-1:0]         WD,
    output logic                      RegWrite,
    output logic [$clog2(DEPTH):0]    count,
    input  logic [ADDR_W-1:0]         fwd_addr,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_rd_mem   [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_rw;
    logic [DATA_W-1:0] r_wd;
    logic              r_regwrite;

    logic              w_full;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_in_rd;
    logic [DATA_W-1:0] w_in_data;

    // Loads win arbitration; readiness never looks at alu_valid.
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign mem_ready = !w_full;
    assign alu_ready = !w_full && !mem_valid;
    assign w_in_rd   = mem_valid ? mem_rd   : alu_rd;
    assign w_in_data = mem_valid ? mem_data : alu_data;
    assign w_accept  = mem_valid ? !w_full : (alu_valid && !w_full);
    assign w_push    = w_accept && (w_in_rd != '0);
    assign w_pop     = !stall && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rw       <= '0;
            r_wd       <= '0;
            r_regwrite <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rw     <= r_rd_mem[r_rd_ptr];
                r_wd     <= r_data_mem[r_rd_ptr];
            end
            r_regwrite <= w_pop;
            r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset: occupancy is defined solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd_mem[r_wr_ptr]   <= w_in_rd;
            r_data_mem[r_wr_ptr] <= w_in_data;
        end
    end

    assign rw       = r_rw;
    assign WD       = r_wd;
    assign RegWrite = r_regwrite;
    assign count    = r_count;

`ifdef REG_WB_FWD_EN
    logic [PTR_W-1:0]  w_age_idx [DEPTH];
    logic [DEPTH-1:0]  w_age_occ;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    // Slot gi of the age view holds the gi-th oldest pending entry.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            assign w_age_idx[gi] = r_rd_ptr + PTR_W'(gi);
            assign w_age_occ[gi] = (CNT_W'(gi) < r_count);
        end
    endgenerate

    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_age_occ[k] && (fwd_addr != '0) && (r_rd_mem[w_age_idx[k]] == fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_data_mem[w_age_idx[k]];
            end
        end
    end

    assign fwd_hit  = w_fwd_hit;
    assign fwd_data = w_fwd_data;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^fwd_addr;
    assign fwd_hit      = 1'b0;
    assign fwd_data     = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed, table-driven bench for reg_writeback_unit; forwarding expectations follow REG_WB_FWD_EN.
module tb_reg_writeback_unit;

`ifdef REG_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_rd;
    logic [15:0] mem_data;
    logic        stall;
    logic [3:0]  rw;
    logic [15:0] WD;
    logic        RegWrite;
    logic [2:0]  count;
    logic [3:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;

    reg_writeback_unit #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .stall(stall), .rw(rw), .WD(WD), .RegWrite(RegWrite), .count(count),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [3:0]  ard;
        logic [15:0] adat;
        logic        mv;
        logic [3:0]  mrd;
        logic [15:0] mdat;
        logic        st;
        logic [3:0]  fa;
        logic        e_we;
        logic [3:0]  e_rw;
        logic [15:0] e_wd;
        logic [2:0]  e_cnt;
        logic        e_ar;
        logic        e_mr;
        logic        e_fh;
        logic [15:0] e_fd;
    } vec_t;

    vec_t vecs_a[$];
    vec_t vecs_b[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic av, input logic [3:0] ard, input logic [15:0] adat,
                                input logic mv, input logic [3:0] mrd, input logic [15:0] mdat,
                                input logic st, input logic [3:0] fa,
                                input logic we, input logic [3:0] erw, input logic [15:0] ewd,
                                input logic [2:0] ecnt, input logic ear, input logic emr,
                                input logic efh, input logic [15:0] efd);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.mv = mv; v.mrd = mrd; v.mdat = mdat;
        v.st = st; v.fa = fa;
        v.e_we = we; v.e_rw = erw; v.e_wd = ewd; v.e_cnt = ecnt;
        v.e_ar = ear; v.e_mr = emr; v.e_fh = efh; v.e_fd = efd;
        return v;
    endfunction

    function automatic logic [15:0] fw(input logic [15:0] d);
        return FWD ? d : 16'h0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
        mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.mdat;
        stall = v.st; fwd_addr = v.fa;
    endtask

    // Drive after a rising edge, compare on the falling edge, then advance one clock.
    task automatic apply(input string tag, input int idx, input vec_t v);
        drive(v);
        @(negedge clk);
        $display("%s[%0d] we=%0b rw=%0d wd=%h cnt=%0d ar=%0b mr=%0b fh=%0b fd=%h",
                 tag, idx, RegWrite, rw, WD, count, alu_ready, mem_ready, fwd_hit, fwd_data);
        check($sformatf("%s%0d.RegWrite", tag, idx), 32'(RegWrite),  32'(v.e_we));
        check($sformatf("%s%0d.rw", tag, idx),       32'(rw),        32'(v.e_rw));
        check($sformatf("%s%0d.WD", tag, idx),       32'(WD),        32'(v.e_wd));
        check($sformatf("%s%0d.count", tag, idx),    32'(count),     32'(v.e_cnt));
        check($sformatf("%s%0d.alu_ready", tag, idx), 32'(alu_ready), 32'(v.e_ar));
        check($sformatf("%s%0d.mem_ready", tag, idx), 32'(mem_ready), 32'(v.e_mr));
        check($sformatf("%s%0d.fwd_hit", tag, idx),  32'(fwd_hit),   32'(v.e_fh));
        check($sformatf("%s%0d.fwd_data", tag, idx), 32'(fwd_data),  32'(v.e_fd));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,16'h0, 0,0,16'h0, 0,0, 0,0,16'h0,0,1,1,0,16'h0);

        // Single write, then ALU/load priority.
        vecs_a.push_back(mk(1,3,16'h1234, 0,0,16'h0,    0,0, 0,0,16'h0000,0,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0000,1,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 1,3,16'h1234,0,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,3,16'h1234,0,1,1,0,16'h0));
        vecs_a.push_back(mk(1,2,16'hAAAA, 1,5,16'h5555, 0,0, 0,3,16'h1234,0,0,1,0,16'h0));
        vecs_a.push_back(mk(1,2,16'hAAAA, 0,0,16'h0,    0,0, 0,3,16'h1234,1,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 1,5,16'h5555,1,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 1,2,16'hAAAA,0,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,2,16'hAAAA,0,1,1,0,16'h0));
        // Fill under stall, then drain.
        vecs_a.push_back(mk(1,1,16'h0001, 0,0,16'h0,    1,0, 0,2,16'hAAAA,0,1,1,0,16'h0));
        vecs_a.push_back(mk(1,2,16'h0002, 0,0,16'h0,    1,0, 0,2,16'hAAAA,1,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    1,3,16'h0003, 1,0, 0,2,16'hAAAA,2,0,1,0,16'h0));
        vecs_a.push_back(mk(1,4,16'h0004, 0,0,16'h0,    1,0, 0,2,16'hAAAA,3,1,1,0,16'h0));
        vecs_a.push_back(mk(1,9,16'h9999, 0,0,16'h0,    1,2, 0,2,16'hAAAA,4,0,0,FWD,fw(16'h0002)));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    1,3, 0,2,16'hAAAA,4,0,0,FWD,fw(16'h0003)));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,2,16'hAAAA,4,0,0,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 1,1,16'h0001,3,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 1,2,16'h0002,2,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 1,3,16'h0003,1,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 1,4,16'h0004,0,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,4,16'h0004,0,1,1,0,16'h0));
        // r0 write is accepted and dropped.
        vecs_a.push_back(mk(1,0,16'hFFFF, 0,0,16'h0,    0,0, 0,4,16'h0004,0,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,4,16'h0004,0,1,1,0,16'h0));
        vecs_a.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,4,16'h0004,0,1,1,0,16'h0));

        // Forwarding: two pending writes to r7, newest wins.
        vecs_b.push_back(mk(1,7,16'h1111, 0,0,16'h0,    1,7, 0,0,16'h0000,0,1,1,0,16'h0));
        vecs_b.push_back(mk(1,7,16'h2222, 0,0,16'h0,    1,7, 0,0,16'h0000,1,1,1,FWD,fw(16'h1111)));
        vecs_b.push_back(mk(0,0,16'h0,    0,0,16'h0,    1,7, 0,0,16'h0000,2,1,1,FWD,fw(16'h2222)));
        vecs_b.push_back(mk(0,0,16'h0,    0,0,16'h0,    1,0, 0,0,16'h0000,2,1,1,0,16'h0));
        vecs_b.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,7, 0,0,16'h0000,2,1,1,FWD,fw(16'h2222)));
        vecs_b.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,7, 1,7,16'h1111,1,1,1,FWD,fw(16'h2222)));
        vecs_b.push_back(mk(0,0,16'h0,    0,0,16'h0,    0,7, 1,7,16'h2222,0,1,1,0,16'h0));

        // Power-on reset.
        drive(idle);
        rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        $display("reset: we=%0b rw=%0d wd=%h cnt=%0d ar=%0b mr=%0b", RegWrite, rw, WD, count, alu_ready, mem_ready);
        check("reset.RegWrite",  32'(RegWrite),  32'd0);
        check("reset.rw",        32'(rw),        32'd0);
        check("reset.WD",        32'(WD),        32'd0);
        check("reset.count",     32'(count),     32'd0);
        check("reset.alu_ready", 32'(alu_ready), 32'd1);
        check("reset.mem_ready", 32'(mem_ready), 32'd1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs_a[i]) apply("A", i, vecs_a[i]);

        // Mid-operation reset discards pending entries and clears the write port.
        alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'hBEEF; stall = 1'b1;
        @(posedge clk); #1;
        alu_rd = 4'd2; alu_data = 16'hCAFE;
        @(posedge clk); #1;
        alu_valid = 1'b0; fwd_addr = 4'd1;
        @(negedge clk);
        $display("pre-reset: cnt=%0d fh=%0b", count, fwd_hit);
        check("midrst.count_before", 32'(count), 32'd2);
        #1 rst = 1'b1;
        #1;
        $display("mid-reset: we=%0b rw=%0d wd=%h cnt=%0d fh=%0b", RegWrite, rw, WD, count, fwd_hit);
        check("midrst.count",    32'(count),    32'd0);
        check("midrst.rw",       32'(rw),       32'd0);
        check("midrst.WD",       32'(WD),       32'd0);
        check("midrst.RegWrite", 32'(RegWrite), 32'd0);
        check("midrst.fwd_hit",  32'(fwd_hit),  32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            $display("post-reset[%0d]: we=%0b cnt=%0d", c, RegWrite, count);
            check($sformatf("postrst%0d.RegWrite", c), 32'(RegWrite), 32'd0);
            check($sformatf("postrst%0d.count", c),    32'(count),    32'd0);
            @(posedge clk); #1;
        end

        foreach (vecs_b[i]) apply("B", i, vecs_b[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
